// File: rtl/intra_acc_pkg.sv
// Shared constants, S1 partial-sum type and clip helpers for intra_filter_accum.
package intra_acc_pkg;

  localparam int PROD_W    = 16;
  localparam int PIX_W     = 8;
  localparam int ROW_LEN   = 32;
  localparam int SHIFT     = 6;
  localparam int SUM_W     = PROD_W + 3;
  localparam int ROUND_OFS = 1 << (SHIFT - 1);
  localparam int PIX_MAX   = (1 << PIX_W) - 1;
  localparam int COL_W     = $clog2(ROW_LEN);

  localparam logic signed [SUM_W-1:0] PIX_MAX_S = SUM_W'(PIX_MAX);

  typedef struct packed {
    logic signed [PROD_W:0] s01;
    logic signed [PROD_W:0] s23;
  } s1_pair_t;

  function automatic logic [PIX_W-1:0] clip_pix(input logic signed [SUM_W-1:0] t);
    logic signed [SUM_W-1:0] r;
    logic [PIX_W-1:0]        pix;
    r = t >>> SHIFT;
    if (r[SUM_W-1]) begin
      pix = {PIX_W{1'b0}};
    end else if (r > PIX_MAX_S) begin
      pix = {PIX_W{1'b1}};
    end else begin
      pix = r[PIX_W-1:0];
    end
    return pix;
  endfunction

  function automatic logic is_clipped(input logic signed [SUM_W-1:0] t);
    logic signed [SUM_W-1:0] r;
    r = t >>> SHIFT;
    return r[SUM_W-1] || (r > PIX_MAX_S);
  endfunction

endpackage

// File: rtl/intra_filter_accum_if.sv
// Tap-product input and pixel output handshake bundle of intra_filter_accum.
interface intra_filter_accum_if;
  import intra_acc_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_p0;
  logic signed [PROD_W-1:0] in_p1;
  logic signed [PROD_W-1:0] in_p2;
  logic signed [PROD_W-1:0] in_p3;
  logic                     out_valid;
  logic                     out_ready;
  logic [PIX_W-1:0]         out_pix;
  logic [COL_W-1:0]         out_col;
  logic                     out_last;

  modport slave (
    input  in_valid, in_p0, in_p1, in_p2, in_p3, out_ready,
    output in_ready, out_valid, out_pix, out_col, out_last
  );

  modport master (
    output in_valid, in_p0, in_p1, in_p2, in_p3, out_ready,
    input  in_ready, out_valid, out_pix, out_col, out_last
  );

endinterface

// File: rtl/intra_acc_stage.sv
// Generic valid/ready pipeline register; loads when empty or when its consumer loads.
module intra_acc_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;
  logic         load_s;

  assign load_s    = !valid_r || out_ready;
  assign in_ready  = load_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Data only moves on a real transfer, so it holds while stalled or bubbling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {W{1'b0}};
    end else if (load_s) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/intra_filter_accum.sv
// Sum/round/shift/clip of four tap products into a column-tagged 8-bit pixel.
// Optional clip statistics counter enabled by defining INTRA_ACC_SAT_STAT_EN.
module intra_filter_accum
  import intra_acc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  intra_filter_accum_if.slave bus
`ifdef INTRA_ACC_SAT_STAT_EN
  ,
  output logic [15:0]         clip_cnt
`endif
);

`ifdef INTRA_ACC_SAT_STAT_EN
  localparam int S3_W = PIX_W + 1;
`else
  localparam int S3_W = PIX_W;
`endif

  s1_pair_t                s1_in_s;
  s1_pair_t                s1_out_s;
  logic signed [SUM_W-1:0] s2_in_s;
  logic signed [SUM_W-1:0] s2_out_s;
  logic [S3_W-1:0]         s3_in_s;
  logic [S3_W-1:0]         s3_out_s;
  logic                    s1_valid_s;
  logic                    s2_valid_s;
  logic                    s3_valid_s;
  logic                    s1_ready_s;
  logic                    s2_ready_s;
  logic                    s3_ready_s;
  logic                    out_hs_s;
  logic [COL_W-1:0]        col_r;

  // Stage datapath: pair sums, rounded total, clipped pixel (+flag).
  always_comb begin
    s1_in_s.s01 = {bus.in_p0[PROD_W-1], bus.in_p0} + {bus.in_p1[PROD_W-1], bus.in_p1};
    s1_in_s.s23 = {bus.in_p2[PROD_W-1], bus.in_p2} + {bus.in_p3[PROD_W-1], bus.in_p3};
    s2_in_s     = {{2{s1_out_s.s01[PROD_W]}}, s1_out_s.s01}
                + {{2{s1_out_s.s23[PROD_W]}}, s1_out_s.s23}
                + SUM_W'(ROUND_OFS);
`ifdef INTRA_ACC_SAT_STAT_EN
    s3_in_s     = {is_clipped(s2_out_s), clip_pix(s2_out_s)};
`else
    s3_in_s     = clip_pix(s2_out_s);
`endif
  end

  intra_acc_stage #(.W($bits(s1_pair_t))) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bus.in_valid), .in_ready(s1_ready_s), .in_data(s1_in_s),
    .out_valid(s1_valid_s), .out_ready(s2_ready_s), .out_data(s1_out_s)
  );

  intra_acc_stage #(.W(SUM_W)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s1_valid_s), .in_ready(s2_ready_s), .in_data(s2_in_s),
    .out_valid(s2_valid_s), .out_ready(s3_ready_s), .out_data(s2_out_s)
  );

  intra_acc_stage #(.W(S3_W)) u_s3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s2_valid_s), .in_ready(s3_ready_s), .in_data(s3_in_s),
    .out_valid(s3_valid_s), .out_ready(bus.out_ready), .out_data(s3_out_s)
  );

  assign out_hs_s      = s3_valid_s && bus.out_ready;
  assign bus.in_ready  = s1_ready_s;
  assign bus.out_valid = s3_valid_s;
  assign bus.out_pix   = s3_out_s[PIX_W-1:0];
  assign bus.out_col   = col_r;
  assign bus.out_last  = (col_r == COL_W'(ROW_LEN - 1));

  // Column position; ROW_LEN is a power of two so the wrap is natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {COL_W{1'b0}};
    end else if (out_hs_s) begin
      col_r <= col_r + COL_W'(1);
    end
  end

`ifdef INTRA_ACC_SAT_STAT_EN
  logic [15:0] clip_cnt_r;

  // Saturating count of clipped pixels actually delivered downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_cnt_r <= 16'h0000;
    end else if (out_hs_s && s3_out_s[PIX_W] && (clip_cnt_r != 16'hFFFF)) begin
      clip_cnt_r <= clip_cnt_r + 16'h0001;
    end
  end

  assign clip_cnt = clip_cnt_r;
`endif

endmodule

// File: doc/intra_filter_accum.md
# intra_filter_accum

Output end of the angular interpolation datapath. Consumes the four signed tap products per predicted sample from the multiple-constant-multiplier blocks, sums them in a pipelined adder tree, rounds, shifts and clips to an 8-bit predicted pixel, and tags each pixel with its column position within the prediction row. Valid/ready handshake on both sides, full throughput of one sample per cycle.

## Interface
- PROD_W, 16: width of each signed tap product.
- PIX_W, 8: width of the unsigned output pixel.
- ROW_LEN, 32: samples per prediction row. Power of two, 4..64.
- SHIFT, 6: normalisation right-shift. The rounding offset is 1 << (SHIFT-1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  tap products are valid.
- in_ready  out  1  block accepts products this cycle.
- in_p0..in_p3  in  PROD_W each  signed tap products, taps 0..3.
- out_valid  out  1  pixel valid.
- out_ready  in  1  downstream accepts the pixel.
- out_pix  out  PIX_W  clipped predicted pixel.
- out_col  out  log2(ROW_LEN)  column index of out_pix.
- out_last  out  1  out_col == ROW_LEN-1.
- clip_cnt  out  16  count of clipped samples. Present only with INTRA_ACC_SAT_STAT_EN.

## Operation
- Three pipeline stages, each with its own valid bit.
- S1 computes s01 = p0+p1 and s23 = p2+p3, each PROD_W+1 bits, sign-extended.
- S2 computes t = s01 + s23 + (1 << (SHIFT-1)) in SUM_W = PROD_W+3 bits. It cannot overflow.
- S3 computes r = t >>> SHIFT (arithmetic). It clips r to [0, 2^PIX_W-1] and registers the result as out_pix.
- Per-stage flow control: stage k loads when it is empty or when stage k+1 loads that cycle. The output stage drains when out_valid && out_ready.
- in_ready = !S1.valid || S1 drains this cycle. Bubbles collapse.
- Input handshake is in_valid && in_ready. Output handshake is out_valid && out_ready.
- in_p* are sampled only on an input handshake.
- While out_valid=1 and out_ready=0, out_pix, out_col and out_last hold stable.
- Column counter col:
  - increments on each output handshake;
  - wraps from ROW_LEN-1 to 0.
- out_col = col. out_last is decoded combinationally from col.
- No reordering or dropping. Every input handshake produces exactly one output handshake, in order.

## Timing
- Latency from input handshake to out_valid is 3 cycles when no stall occurs.
- Throughput is 1 sample/cycle when out_ready is held at 1.
- Simultaneous accept and drain on any stage is legal and preserves throughput.
- Stall: when out_ready=0, the pipeline fills. in_ready drops once all three stages are occupied and not draining.
- Reset values: out_valid=0, out_pix=0, out_col=0, out_last=0, in_ready=1 (combinational from the empty pipe), clip_cnt=0, all stage valids 0.
- Reset mid-operation: all in-flight samples are discarded and col returns to 0. No output handshake is generated for them.
- Row wrap: the handshake with out_last=1 returns col to 0. The following pixel has out_col=0.

## Configuration
- INTRA_ACC_SAT_STAT_EN defined:
  - clip_cnt increments on each output handshake whose sample was clipped high or low;
  - clip_cnt saturates at 16'hFFFF and never wraps;
  - a per-sample clip flag travels alongside S3.
- Not defined: the clip_cnt port, counter and flag are absent. All other behaviour is identical.

## Structure
- Package intra_acc_pkg holds:
  - PROD_W, PIX_W, SHIFT defaults;
  - SUM_W = PROD_W+3;
  - ROUND_OFS = 1 << (SHIFT-1);
  - PIX_MAX = 2^PIX_W-1;
  - a typedef for the S1 partial-sum pair.
- Sub-module intra_acc_stage: a generic valid/ready pipeline register with data width as a parameter, instantiated three times.

## Test plan
- Unity-gain taps: p = (-200, 5800, 1000, -200), out_ready=1 → out_pix=100 exactly 3 cycles after the handshake, out_col=0.
- Rounding edge:
  - p = (31, 0, 0, 0) → out_pix=0;
  - p = (32, 0, 0, 0) → out_pix=1.
- Clip:
  - p = (0, 16384, 16384, 0) → out_pix=255;
  - p = (-765, 0, 0, 0) → out_pix=0;
  - with the macro, clip_cnt=2 after both.
- Extreme products: p = (32767, 32767, 32767, 32767) → out_pix=255 with no wrap. p = (-32768) ×4 → out_pix=0.
- Backpressure: stream 40 samples with out_ready toggling pseudo-randomly.
  - all 40 samples emerge in order;
  - no pixel changes while stalled;
  - in_ready=0 only when 3 samples are held;
  - out_last at samples 31 and 39 is 1 and 0 respectively, and out_col=7 on sample 39.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight → out_valid=0 immediately. After release, the next sample emerges with out_col=0 and clip_cnt=0.
